// File: rtl/video_timing_gen.sv
// Programmable video timing generator with a valid/ready pixel stream, SOF lock tracking and a pixel clock-enable.
// Optional build macro VIDEO_TEST_PATTERN_EN adds the pattern_sel input (8 vertical colour bars).
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 4,
  parameter int NUM_CH   = 3,
  parameter int IN_BPC   = 8,
  parameter int OUT_BPC  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*IN_BPC-1:0]  pix_data,
  input  logic                      pix_sof,
  input  logic                      pix_valid,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  output logic                      pix_ready,
  output logic [NUM_CH*OUT_BPC-1:0] HDMI_DATA,
  output logic                      HDMI_HSYNC,
  output logic                      HDMI_VSYNC,
  output logic                      HDMI_EN,
  output logic                      pix_ce,
  output logic                      frame_start,
  output logic                      locked,
  output logic                      underflow,
  output logic                      sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          HS_LVL   = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          VS_LVL   = (VS_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                    state, state_next;
  logic [DW-1:0]             div_cnt, div_next;
  logic [HW-1:0]             h_cnt;
  logic [VW-1:0]             v_cnt;
  logic                      active, first, hs_on, vs_on, sof_ok;
  logic                      pat_on, take, uf_hit, se_hit;
  logic [NUM_CH*OUT_BPC-1:0] pix_out;

  // Each channel keeps its position and is left-aligned with zero LSB padding.
  function automatic logic [NUM_CH*OUT_BPC-1:0] pack_pixel(input logic [NUM_CH*IN_BPC-1:0] d);
    logic [NUM_CH*OUT_BPC-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      r[c*OUT_BPC +: OUT_BPC] = OUT_BPC'(d[c*IN_BPC +: IN_BPC]) << (OUT_BPC - IN_BPC);
    end
    return r;
  endfunction

  function automatic logic [NUM_CH*OUT_BPC-1:0] bar_pixel(input logic [HW-1:0] h);
    logic [NUM_CH*OUT_BPC-1:0] r;
    logic [2:0]                k;
    r = '0;
    k = 3'(int'(h) / BAR_W);
    for (int c = 0; c < NUM_CH; c++) begin
      if (c < 3) begin
        if (k[2-c]) begin
          r[(NUM_CH-1-c)*OUT_BPC +: OUT_BPC] = '1;
        end
      end
    end
    return r;
  endfunction

`ifdef VIDEO_TEST_PATTERN_EN
  assign pat_on = pattern_sel;
`else
  assign pat_on = 1'b0;
`endif

  // Region decode from the current (pre-increment) counters.
  always_comb begin
    active   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    first    = (h_cnt == {HW{1'b0}}) && (v_cnt == {VW{1'b0}});
    hs_on    = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_on    = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    sof_ok   = (pix_sof == first);
    div_next = (div_cnt == DIV_LAST) ? {DW{1'b0}} : (div_cnt + DW'(1'b1));
  end

  // Lock FSM: next state, stream handshake and error detection.
  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    take       = 1'b0;
    uf_hit     = 1'b0;
    se_hit     = 1'b0;
    if (pat_on) begin
      pix_ready  = 1'b1;
      state_next = UNLOCKED;
    end else begin
      case (state)
        UNLOCKED: begin
          if (pix_ce && first && pix_valid && pix_sof) begin
            pix_ready  = 1'b1;
            take       = 1'b1;
            state_next = LOCKED;
          end else begin
            pix_ready = pix_valid && !pix_sof;
          end
        end
        LOCKED: begin
          // A misplaced SOF is refused so it can be re-presented at (0,0).
          pix_ready = pix_ce && active && sof_ok;
          if (pix_ce && active) begin
            if (!pix_valid) begin
              uf_hit     = 1'b1;
              state_next = UNLOCKED;
            end else if (!sof_ok) begin
              se_hit     = 1'b1;
              state_next = UNLOCKED;
            end else begin
              take = 1'b1;
            end
          end else begin
            state_next = LOCKED;
          end
        end
        default: begin
          state_next = UNLOCKED;
        end
      endcase
    end
  end

  // Pixel value selected for the next strobe.
  always_comb begin
    if (pat_on && active) begin
      pix_out = bar_pixel(h_cnt);
    end else if (take) begin
      pix_out = pack_pixel(pix_data);
    end else begin
      pix_out = '0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= UNLOCKED;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Divider, raster counters and registered video outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt     <= {DW{1'b0}};
      pix_ce      <= 1'b0;
      h_cnt       <= {HW{1'b0}};
      v_cnt       <= {VW{1'b0}};
      HDMI_DATA   <= '0;
      HDMI_EN     <= 1'b0;
      HDMI_HSYNC  <= ~HS_LVL;
      HDMI_VSYNC  <= ~VS_LVL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      pix_ce    <= (div_next == DIV_LAST);
      underflow <= uf_hit;
      sync_err  <= se_hit;
      if (pix_ce) begin
        HDMI_DATA   <= pix_out;
        HDMI_EN     <= active;
        HDMI_HSYNC  <= hs_on ? HS_LVL : ~HS_LVL;
        HDMI_VSYNC  <= vs_on ? VS_LVL : ~VS_LVL;
        frame_start <= first;
        if (h_cnt == H_LAST) begin
          h_cnt <= {HW{1'b0}};
          v_cnt <= (v_cnt == V_LAST) ? {VW{1'b0}} : (v_cnt + VW'(1'b1));
        end else begin
          h_cnt <= h_cnt + HW'(1'b1);
        end
      end
    end
  end

endmodule
